// File: rtl/dac_sample_pacer_if.sv
// Upstream sample-pair handshake between the synthesis pipeline and the DAC pacer.
interface dac_sample_pacer_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_left;
  logic [WIDTH-1:0] in_right;

  // Producer side: offers a left/right pair, watches for room in the FIFO.
  modport master (
    output in_valid,
    output in_left,
    output in_right,
    input  in_ready
  );

  // Pacer side: accepts pairs whenever its FIFO is not full.
  modport slave (
    input  in_valid,
    input  in_left,
    input  in_right,
    output in_ready
  );
endinterface

// File: rtl/dac_sample_pacer.sv
// Sample-rate pacer for the stereo DAC: buffers bursty left/right pairs in a
// small FIFO and releases exactly one pair every SAMPLE_TIME clocks once primed.
module dac_sample_pacer #(
  parameter int WIDTH       = 4,
  parameter int SAMPLE_TIME = 128,
  parameter int DEPTH       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  dac_sample_pacer_if.slave  up,
  output logic [WIDTH-1:0]   left,
  output logic [WIDTH-1:0]   right,
  output logic               sample_tick,
  output logic               underrun,
  output logic [7:0]         underrun_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int DW = (SAMPLE_TIME > 1) ? $clog2(SAMPLE_TIME) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_TIME - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_PRIME = LW'(DEPTH / 2);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t state_q, state_d;

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [LW-1:0]      level;
  logic [DW-1:0]      div_q;

  logic full, empty, push, pop, starve;
  logic div_en, pop_try;

  // Ready is a pure function of the registered level; a same-edge pop does not
  // open a slot early, which keeps the upstream ready path short.
  assign full        = (level == LVL_FULL);
  assign empty       = (level == '0);
  assign up.in_ready = !full;
  assign push        = up.in_valid && !full;
  assign pop         = pop_try && !empty;
  assign starve      = pop_try && empty;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: prime to half depth before pacing, fall back to PRIME on starvation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = PRIME;
      PRIME: begin
        if (!enable)                 state_d = IDLE;
        else if (level >= LVL_PRIME) state_d = RUN;
      end
      RUN: begin
        if (!enable)                state_d = IDLE;
        else if (pop_try && empty) state_d = PRIME;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: the divider only runs in an enabled RUN cycle, and its last count is the tick.
  always_comb begin
    div_en  = 1'b0;
    pop_try = 1'b0;
    if (state_q == RUN && enable) begin
      div_en  = 1'b1;
      pop_try = (div_q == DIV_LAST);
    end
  end

  // Sample-period divider; cleared whenever pacing is not running or on a tick.
  always_ff @(posedge clk) begin
    if (reset)                 div_q <= '0;
    else if (!div_en || pop_try) div_q <= '0;
    else                       div_q <= div_q + DW'(1);
  end

  // FIFO storage; contents need no reset because the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= {up.in_left, up.in_right};
  end

  // FIFO pointers and occupancy; push and pop on the same edge cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  // DAC outputs and status pulses; on an empty tick the last sample is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      left           <= '0;
      right          <= '0;
      sample_tick    <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      sample_tick <= pop_try;
      underrun    <= starve;
      if (pop) {left, right} <= mem[rd_ptr];
      if (starve && underrun_count != 8'hFF) underrun_count <= underrun_count + 8'd1;
    end
  end

endmodule
